cheri_mem_port_arbiter: RTL

//  Shares one single-port tightly-coupled SRAM between the CHERIoT core's instr fetch, data and

---
 rtl/cheri_mem_port_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/cheri_mem_port_arbiter.sv
// cheri_mem_port_arbiter
// Shares one single-port tightly-coupled SRAM between instruction fetch, data
// and tsmap requesters. tsmap reads have absolute priority and are never
// stalled; instr and data are arbitrated round-robin. The SRAM answers one
// cycle after select, so a single in-flight entry tracks who owns the
// returning row, which word lane to steer out and whether it was out of range.
// Optional feature macro: ARB_PERF_CNT_EN adds two saturating event counters.
module cheri_mem_port_arbiter #(
  parameter int unsigned DataWidth = 33,
  parameter logic [31:0] MemBase   = 32'h200f_0000,
  parameter int unsigned MemRows   = 16384,
  parameter int unsigned TSMapOfs  = 32'h3800,
  localparam int unsigned AW       = $clog2(MemRows),
  localparam int unsigned BeW      = (DataWidth - 1) / 8,
  localparam int unsigned TagW     = DataWidth / 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 instr_req_i,
  input  logic [31:0]          instr_addr_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  output logic [31:0]          instr_rdata_o,
  output logic                 instr_err_o,
  input  logic                 data_req_i,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [32:0]          data_wdata_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  output logic [32:0]          data_rdata_o,
  output logic                 data_err_o,
  input  logic                 tsmap_cs_i,
  input  logic [15:0]          tsmap_addr_i,
  output logic [31:0]          tsmap_rdata_o,
  output logic                 mem_cs_o,
  output logic                 mem_we_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [BeW-1:0]       mem_be_o,
  output logic [TagW-1:0]      mem_tag_we_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic [DataWidth-1:0] mem_rdata_i
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_tsmap_stall_o,
  output logic [31:0]          perf_rr_conflict_o
`endif
);

  localparam bit          Wide     = (DataWidth == 65);
  localparam int unsigned RowShift = Wide ? 3 : 2;

  typedef enum logic [1:0] {
    OWN_INSTR = 2'd0,
    OWN_DATA  = 2'd1,
    OWN_TSMAP = 2'd2
  } owner_e;

  // Row index of a byte address relative to the SRAM base.
  function automatic logic [31:0] row_of(input logic [31:0] addr);
    return (addr - MemBase) >> RowShift;
  endfunction

  // Address falls below the base or beyond the last row.
  function automatic logic addr_oor(input logic [31:0] addr);
    logic [31:0] row;
    row = row_of(addr);
    return (addr < MemBase) || (row >= 32'(MemRows));
  endfunction

  // Word lane inside a two-word row; always lane 0 for one-word rows.
  function automatic logic lane_of(input logic [31:0] addr);
    return Wide ? addr[2] : 1'b0;
  endfunction

  // Request-cycle decision (p0) and in-flight entry (p1)
  logic   vld_p0, lane_p0, err_p0, we_p0;
  owner_e owner_p0;
  logic   vld_p1, lane_p1, err_p1, we_p1;
  owner_e owner_p1;

  // Round-robin pointer: 0 favours instr, 1 favours data
  logic   rr_ptr, ptr_nxt;

  // Arbitrate the shared port and build the SRAM command for this cycle.
  always_comb begin
    instr_gnt_o  = 1'b0;
    data_gnt_o   = 1'b0;
    mem_cs_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_be_o     = '0;
    mem_tag_we_o = '0;
    vld_p0       = 1'b0;
    owner_p0     = OWN_INSTR;
    lane_p0      = 1'b0;
    err_p0       = 1'b0;
    we_p0        = 1'b0;
    ptr_nxt      = rr_ptr;
    if (!rst_i) begin
      if (tsmap_cs_i) begin
        mem_cs_o   = 1'b1;
        mem_addr_o = AW'(TSMapOfs) + AW'(tsmap_addr_i);
        vld_p0     = 1'b1;
        owner_p0   = OWN_TSMAP;
      end else if (instr_req_i && (!data_req_i || !rr_ptr)) begin
        instr_gnt_o = 1'b1;
        vld_p0      = 1'b1;
        owner_p0    = OWN_INSTR;
        lane_p0     = lane_of(instr_addr_i);
        err_p0      = addr_oor(instr_addr_i);
        ptr_nxt     = 1'b1;
        if (!err_p0) begin
          mem_cs_o   = 1'b1;
          mem_addr_o = AW'(row_of(instr_addr_i));
        end
      end else if (data_req_i) begin
        data_gnt_o = 1'b1;
        vld_p0     = 1'b1;
        owner_p0   = OWN_DATA;
        lane_p0    = lane_of(data_addr_i);
        err_p0     = addr_oor(data_addr_i);
        we_p0      = data_we_i;
        ptr_nxt    = 1'b0;
        if (!err_p0) begin
          mem_cs_o   = 1'b1;
          mem_we_o   = data_we_i;
          mem_addr_o = AW'(row_of(data_addr_i));
          mem_be_o   = BeW'(data_be_i) << (lane_p0 ? 4 : 0);
          if (data_we_i) begin
            mem_tag_we_o = TagW'(1) << lane_p0;
          end
        end
      end
    end
  end

  // Write row: the data word is replicated into both lanes of a wide row.
  if (Wide) begin : g_wdata_wide
    assign mem_wdata_o = {data_wdata_i[32], data_wdata_i[31:0], data_wdata_i[31:0]};
  end else begin : g_wdata_narrow
    assign mem_wdata_o = data_wdata_i;
  end

  // ---- p0 -> p1: capture the in-flight entry and advance the RR pointer ----
  // Control-only state; reset drops any pending response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      owner_p1 <= OWN_INSTR;
      lane_p1  <= 1'b0;
      err_p1   <= 1'b0;
      we_p1    <= 1'b0;
      rr_ptr   <= 1'b0;
    end else begin
      vld_p1   <= vld_p0;
      owner_p1 <= owner_p0;
      lane_p1  <= lane_p0;
      err_p1   <= err_p0;
      we_p1    <= we_p0;
      rr_ptr   <= ptr_nxt;
    end
  end

  // Response steering from the returning row
  logic [31:0] rd_word;
  logic        rd_tag;
  logic        instr_hit, data_hit, tsmap_hit;

  assign rd_word   = 32'(mem_rdata_i >> (lane_p1 ? 32 : 0));
  assign rd_tag    = mem_rdata_i[DataWidth-1];

  assign instr_hit = vld_p1 && (owner_p1 == OWN_INSTR) && !rst_i;
  assign data_hit  = vld_p1 && (owner_p1 == OWN_DATA)  && !rst_i;
  assign tsmap_hit = vld_p1 && (owner_p1 == OWN_TSMAP) && !rst_i;

  assign instr_rvalid_o = instr_hit;
  assign instr_err_o    = instr_hit && err_p1;
  assign instr_rdata_o  = (instr_hit && !err_p1) ? rd_word : '0;

  assign data_rvalid_o  = data_hit;
  assign data_err_o     = data_hit && err_p1;
  assign data_rdata_o   = (data_hit && !err_p1 && !we_p1) ? {rd_tag, rd_word} : '0;

  assign tsmap_rdata_o  = tsmap_hit ? mem_rdata_i[31:0] : '0;

`ifdef ARB_PERF_CNT_EN
  // Count cycles where tsmap blocks a requester and where instr and data collide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_tsmap_stall_o <= '0;
      perf_rr_conflict_o <= '0;
    end else begin
      if (tsmap_cs_i && (instr_req_i || data_req_i) && (perf_tsmap_stall_o != '1)) begin
        perf_tsmap_stall_o <= perf_tsmap_stall_o + 32'd1;
      end
      if (instr_req_i && data_req_i && (perf_rr_conflict_o != '1)) begin
        perf_rr_conflict_o <= perf_rr_conflict_o + 32'd1;
      end
    end
  end
`endif

endmodule
